eqed_inject_ctrl: RTL and testbench

- Run-level sequencer for EQED single-bit-flip campaigns on a design under test (DUT) instrumented with per-FF inverting muxes.
- Accepts a target FF index, an injection cycle and a run length, then counts cycles from run start.
- Drives the one-hot mux-select vector for exactly one cycle and guarantees at most one injection per run.
- Sits between the formal harness (MISRs, cover/assume properties) and the DUT's select bus. It replaces the ad-hoc decoder, error_injected and cycle_count logic in the harness.

---
 rtl/eqed_inject_ctrl_if.sv | 28 ++
 rtl/eqed_inject_ctrl.sv | 93 +++++++++
 tb/tb_eqed_inject_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/eqed_inject_ctrl_if.sv
// Control/select bundle between the EQED formal harness (master) and the
// injection sequencer (slave).
interface eqed_inject_ctrl_if #(
    parameter int N_FF  = 8,
    parameter int IDX_W = 4,
    parameter int CNT_W = 10
);
    logic             start;
    logic             abort;
    logic [IDX_W-1:0] tgt_idx;
    logic [CNT_W-1:0] inj_cycle;
    logic [CNT_W-1:0] run_len;
    logic [N_FF-1:0]  sel;
    logic             injected;
    logic [CNT_W-1:0] cycle_count;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, tgt_idx, inj_cycle, run_len,
        input  sel, injected, cycle_count, busy, done
    );

    modport slave (
        input  start, abort, tgt_idx, inj_cycle, run_len,
        output sel, injected, cycle_count, busy, done
    );
endinterface

// File: rtl/eqed_inject_ctrl.sv
// Run-level sequencer for single-bit-flip campaigns: counts run cycles and
// drives a one-hot flip select for at most one cycle per run.
module eqed_inject_ctrl #(
    parameter int N_FF  = 8,
    parameter int IDX_W = 4,
    parameter int CNT_W = 10
) (
    input logic              clk,
    input logic              rst,
    eqed_inject_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Any latched target at or above this index is a golden run.
    localparam logic [IDX_W-1:0] NO_INJ_IDX = IDX_W'(N_FF);

    state_t           state;
    logic [IDX_W-1:0] tgt_q;
    logic [CNT_W-1:0] inj_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cycle_count;
    logic             injected;
    logic             busy;
    logic             done;
    logic [N_FF-1:0]  sel;

    // Decoded from registers only, so no input can reach the DUT muxes.
    always_comb begin
        sel = '0;
        if (state == RUN && cycle_count == inj_q && !injected && tgt_q < NO_INJ_IDX)
            sel = N_FF'(1) << tgt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tgt_q       <= '0;
            inj_q       <= '0;
            len_q       <= '0;
            cycle_count <= '0;
            injected    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // A flip in this cycle is recorded even if the run is aborted now.
            if (|sel)
                injected <= 1'b1;

            if (bus.abort) begin
                state       <= IDLE;
                cycle_count <= '0;
                busy        <= 1'b0;
                done        <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (bus.start) begin
                            tgt_q       <= bus.tgt_idx;
                            inj_q       <= bus.inj_cycle;
                            len_q       <= (bus.run_len == '0) ? CNT_W'(1) : bus.run_len;
                            cycle_count <= CNT_W'(1);
                            injected    <= 1'b0;
                            state       <= RUN;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (cycle_count == len_q) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cycle_count <= cycle_count + CNT_W'(1);
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        cycle_count <= '0;
                        busy        <= 1'b0;
                        done        <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sel         = sel;
    assign bus.injected    = injected;
    assign bus.cycle_count = cycle_count;
    assign bus.busy        = busy;
    assign bus.done        = done;
endmodule

// File: tb/tb_eqed_inject_ctrl.sv
// Directed bench for eqed_inject_ctrl: injection, golden, out-of-window,
// ignored start, abort, async reset and back-to-back runs.
module tb_eqed_inject_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    eqed_inject_ctrl_if #(.N_FF(8), .IDX_W(4), .CNT_W(10)) bus ();

    eqed_inject_ctrl #(.N_FF(8), .IDX_W(4), .CNT_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_checks(input string tag, input logic exp_inj);
        chk({tag, " sel"},      32'(bus.sel), 32'h0);
        chk({tag, " busy"},     32'(bus.busy), 32'h0);
        chk({tag, " done"},     32'(bus.done), 32'h0);
        chk({tag, " count"},    32'(bus.cycle_count), 32'h0);
        chk({tag, " injected"}, 32'(bus.injected), 32'(exp_inj));
    endtask

    // Start a run and check every RUN cycle plus the DONE state that follows.
    task automatic do_run(input string tag, input logic [3:0] t, input logic [9:0] ic,
                          input logic [9:0] rl, input int eff_len,
                          input logic [7:0] exp_sel, input int sel_cyc);
        bus.tgt_idx   = t;
        bus.inj_cycle = ic;
        bus.run_len   = rl;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= eff_len; c++) begin
            chk({tag, " count"}, 32'(bus.cycle_count), 32'(c));
            chk({tag, " busy"},  32'(bus.busy), 32'h1);
            chk({tag, " sel"},   32'(bus.sel), (c == sel_cyc) ? 32'(exp_sel) : 32'h0);
            chk({tag, " injected"}, 32'(bus.injected),
                (sel_cyc != 0 && c > sel_cyc) ? 32'h1 : 32'h0);
            tick();
        end
        chk({tag, " done"},       32'(bus.done), 32'h1);
        chk({tag, " done busy"},  32'(bus.busy), 32'h0);
        chk({tag, " done count"}, 32'(bus.cycle_count), 32'(eff_len));
        chk({tag, " done sel"},   32'(bus.sel), 32'h0);
        chk({tag, " done inj"},   32'(bus.injected), (sel_cyc != 0) ? 32'h1 : 32'h0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.tgt_idx   = '0;
        bus.inj_cycle = '0;
        bus.run_len   = '0;

        #1 rst = 1'b1;
        #2;
        idle_checks("reset", 1'b0);
        tick();
        rst = 1'b0;
        tick();
        idle_checks("post reset", 1'b0);

        do_run("ff5", 4'd5, 10'd4, 10'd6, 6, 8'h20, 4);
        tick();
        chk("ff5 hold count", 32'(bus.cycle_count), 32'd6);
        chk("ff5 hold done",  32'(bus.done), 32'h1);

        do_run("golden", 4'd8, 10'd2, 10'd5, 5, 8'h00, 0);
        do_run("late",   4'd3, 10'd9, 10'd6, 6, 8'h00, 0);
        do_run("zero",   4'd3, 10'd0, 10'd6, 6, 8'h00, 0);
        do_run("len0",   4'd3, 10'd1, 10'd0, 1, 8'h08, 1);

        // Start pulsed at cycle 3 with different config must be ignored.
        bus.tgt_idx = 4'd2; bus.inj_cycle = 10'd3; bus.run_len = 10'd6; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("ign c3 count", 32'(bus.cycle_count), 32'd3);
        chk("ign c3 sel",   32'(bus.sel), 32'h04);
        bus.tgt_idx = 4'd7; bus.inj_cycle = 10'd1; bus.run_len = 10'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ign c4 count", 32'(bus.cycle_count), 32'd4);
        chk("ign c4 inj",   32'(bus.injected), 32'h1);
        chk("ign c4 busy",  32'(bus.busy), 32'h1);
        tick();
        chk("ign c5 count", 32'(bus.cycle_count), 32'd5);
        tick();
        chk("ign c6 count", 32'(bus.cycle_count), 32'd6);
        chk("ign c6 busy",  32'(bus.busy), 32'h1);
        tick();
        chk("ign done",     32'(bus.done), 32'h1);
        chk("ign done cnt", 32'(bus.cycle_count), 32'd6);

        // Abort at cycle 2, before the injection cycle.
        bus.tgt_idx = 4'd1; bus.inj_cycle = 10'd4; bus.run_len = 10'd6; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("abort c1 inj", 32'(bus.injected), 32'h0);
        tick();
        chk("abort c2 count", 32'(bus.cycle_count), 32'd2);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        idle_checks("abort", 1'b0);
        tick();
        tick();
        tick();
        idle_checks("abort later", 1'b0);

        // Abort coinciding with the injection cycle still flips.
        bus.tgt_idx = 4'd6; bus.inj_cycle = 10'd2; bus.run_len = 10'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("abort inj sel", 32'(bus.sel), 32'h40);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        idle_checks("abort inj", 1'b1);

        // Asynchronous reset between edges while sel is asserted.
        bus.tgt_idx = 4'd2; bus.inj_cycle = 10'd2; bus.run_len = 10'd6; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("arst pre sel", 32'(bus.sel), 32'h04);
        #2 rst = 1'b1;
        #1;
        idle_checks("arst", 1'b0);
        #1 rst = 1'b0;
        tick();
        idle_checks("arst after", 1'b0);

        // Back-to-back: injected run, then start straight from DONE.
        do_run("b2b a", 4'd7, 10'd2, 10'd3, 3, 8'h80, 2);
        do_run("b2b b", 4'd0, 10'd1, 10'd2, 2, 8'h01, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
